// File: rtl/z80_bus_master.sv
// Z80-style bus initiator: turns single host requests into I/O write, I/O read
// and M1 opcode-fetch cycles. The FSM, strobes and data path all share one registered process.
module z80_bus_master #(
  parameter int unsigned IO_WAIT      = 1,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [1:0]  cmd,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in,
  output logic        mreq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        m1_n,
  input  logic        wait_n
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_END} state_t;
  typedef enum logic [1:0] {
    CMD_IOWR = 2'b00,
    CMD_IORD = 2'b01,
    CMD_M1   = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_t;

  localparam logic [2:0] AUTO_WAITS = 3'(IO_WAIT);
  localparam logic [7:0] WCNT_LAST  = 8'(WAIT_TIMEOUT - 1);

  state_t     r_state;
  cmd_t       r_cmd;
  logic [2:0] r_auto;
  logic [7:0] r_wcnt;

  // Outputs are updated with the state they belong to, so each strobe changes
  // exactly on the edge that enters its state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every register gets a reset value here; there is no storage array
      // in this block, so nothing is left to power up undefined.
      r_state <= S_IDLE;
      r_cmd   <= CMD_IOWR;
      r_auto  <= '0;
      r_wcnt  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      a       <= '0;
      d_out   <= '0;
      d_oe    <= 1'b0;
      mreq_n  <= 1'b1;
      iorq_n  <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      m1_n    <= 1'b1;
    end else begin
      // NOTE: done/err default low every clock, so the assignments below
      // produce single-cycle pulses without a separate clear path.
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req && cmd != CMD_RSVD) begin
            r_cmd   <= cmd_t'(cmd);
            a       <= addr;
            r_auto  <= (cmd == CMD_M1) ? 3'd0 : AUTO_WAITS;
            r_wcnt  <= '0;
            busy    <= 1'b1;
            if (cmd == CMD_IOWR) begin
              d_out <= wdata;
              d_oe  <= 1'b1;
            end
            r_state <= S_T1;
          end
        end
        S_T1: begin
          iorq_n  <= (r_cmd == CMD_M1);
          mreq_n  <= (r_cmd != CMD_M1);
          m1_n    <= (r_cmd != CMD_M1);
          rd_n    <= (r_cmd == CMD_IOWR);
          wr_n    <= (r_cmd != CMD_IOWR);
          r_state <= S_T2;
        end
        S_T2, S_TW: begin
          // A low wait_n adds one TW on top of any automatic waits still owed.
          if (!wait_n) begin
            if (r_wcnt == WCNT_LAST) begin
              done    <= 1'b1;
              err     <= 1'b1;
              mreq_n  <= 1'b1;
              iorq_n  <= 1'b1;
              rd_n    <= 1'b1;
              wr_n    <= 1'b1;
              m1_n    <= 1'b1;
              r_state <= S_END;
            end else begin
              r_wcnt  <= r_wcnt + 8'd1;
              r_state <= S_TW;
            end
          end else begin
            r_wcnt <= '0;
            if (r_auto != 3'd0) begin
              r_auto  <= r_auto - 3'd1;
              r_state <= S_TW;
            end else begin
              r_state <= S_T3;
            end
          end
        end
        S_T3: begin
          if (r_cmd != CMD_IOWR) rdata <= d_in;
          done    <= 1'b1;
          mreq_n  <= 1'b1;
          iorq_n  <= 1'b1;
          rd_n    <= 1'b1;
          wr_n    <= 1'b1;
          m1_n    <= 1'b1;
          r_state <= S_END;
        end
        S_END: begin
          busy    <= 1'b0;
          d_oe    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// Scoreboard bench for z80_bus_master: each request pushes its expected cycle
// length, strobe widths and result; a negedge monitor pops and compares on done.
module tb_z80_bus_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  d_in = '0;
  logic        wait_n = 1'b1;
  logic        busy, done, err, d_oe;
  logic [7:0]  rdata, d_out;
  logic [15:0] a;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;

  z80_bus_master #(.IO_WAIT(1), .WAIT_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .cmd(cmd), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .a(a), .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .mreq_n(mreq_n),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .wait_n(wait_n)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  typedef struct {
    int          acc;
    int          lat;
    logic        err;
    logic [7:0]  rdata;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          n_iorq, n_mreq, n_rd, n_wr, n_m1, n_doe;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic e, input logic [7:0] rd,
                              input logic [15:0] ad, input logic [7:0] wd,
                              input int ni, input int nm, input int nr,
                              input int nw, input int n1, input int nd);
    exp_t x;
    x.acc = 0; x.lat = lat; x.err = e; x.rdata = rd; x.addr = ad; x.wdata = wd;
    x.n_iorq = ni; x.n_mreq = nm; x.n_rd = nr; x.n_wr = nw; x.n_m1 = n1; x.n_doe = nd;
    return x;
  endfunction

  // Monitor: strobe-width counters, edge checks and scoreboard pop on done.
  int         c_iorq = 0, c_mreq = 0, c_rd = 0, c_wr = 0, c_m1 = 0, c_doe = 0, c_busy = 0;
  logic       prev_wr = 1'b1, prev_m1 = 1'b1;
  logic [7:0] ctrl_reg = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      c_iorq = 0; c_mreq = 0; c_rd = 0; c_wr = 0; c_m1 = 0; c_doe = 0; c_busy = 0;
      prev_wr = 1'b1; prev_m1 = 1'b1;
    end else begin
      c_iorq += int'(!iorq_n); c_mreq += int'(!mreq_n); c_rd += int'(!rd_n);
      c_wr   += int'(!wr_n);   c_m1   += int'(!m1_n);   c_doe += int'(d_oe);
      c_busy += int'(busy);
      if (wr_n && !prev_wr) begin
        check("wr_rise_doe", 32'(d_oe), 32'd1);
        if (sb.size() > 0) check("wr_rise_data", 32'(d_out), 32'(sb[0].wdata));
        if (a == 16'h0040) ctrl_reg = d_out;
      end
      if (m1_n && !prev_m1) check("m1_rise_together", 32'({mreq_n, rd_n}), 32'b11);
      prev_wr = wr_n;
      prev_m1 = m1_n;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_latency", 32'(cnt - e.acc), 32'(e.lat));
          check("err", 32'(err), 32'(e.err));
          check("rdata", 32'(rdata), 32'(e.rdata));
          check("addr_bus", 32'(a), 32'(e.addr));
          check("iorq_width", 32'(c_iorq), 32'(e.n_iorq));
          check("mreq_width", 32'(c_mreq), 32'(e.n_mreq));
          check("rd_width", 32'(c_rd), 32'(e.n_rd));
          check("wr_width", 32'(c_wr), 32'(e.n_wr));
          check("m1_width", 32'(c_m1), 32'(e.n_m1));
          check("doe_width", 32'(c_doe), 32'(e.n_doe));
        end
        c_iorq = 0; c_mreq = 0; c_rd = 0; c_wr = 0; c_m1 = 0; c_doe = 0; c_busy = 0;
      end
    end
  end

  // Drive one request; wait_n is low in periods N+w_from .. N+w_to-1.
  task automatic run(input string tag, input logic [1:0] c, input logic [15:0] ad,
                     input logic [7:0] wd, input logic [7:0] din,
                     input int w_from, input int w_to, input exp_t e);
    @(posedge clk); #1;
    req = 1'b1; cmd = c; addr = ad; wdata = wd; d_in = din;
    e.acc = cnt;
    sb.push_back(e);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      req = 1'b0;
      wait_n = !(k >= w_from && k < w_to);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check({"timeout_", tag}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    wait_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", 32'({mreq_n, iorq_n, rd_n, wr_n, m1_n}), 32'h1f);
    check("rst_ctl", 32'({d_oe, busy, done, err}), 32'h0);
    check("rst_data", {rdata, a, d_out}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;

    run("io_write", 2'b00, 16'h0040, 8'hA5, 8'h00, 0, 0,
        mk(5, 1'b0, 8'h00, 16'h0040, 8'hA5, 3, 0, 0, 3, 0, 5));
    check("ctrl_out_readback", 32'(ctrl_reg), 32'hA5);

    run("io_read", 2'b01, 16'h0041, 8'h00, 8'h3C, 0, 0,
        mk(5, 1'b0, 8'h3C, 16'h0041, 8'h00, 3, 0, 3, 0, 0, 0));

    run("m1_fetch", 2'b10, 16'h1234, 8'h00, 8'hED, 0, 0,
        mk(4, 1'b0, 8'hED, 16'h1234, 8'h00, 0, 2, 2, 0, 2, 0));

    run("io_read_wait4", 2'b01, 16'h0042, 8'h00, 8'h5A, 2, 6,
        mk(9, 1'b0, 8'h5A, 16'h0042, 8'h00, 7, 0, 7, 0, 0, 0));

    run("io_read_timeout", 2'b01, 16'h0043, 8'h00, 8'h77, 2, 100,
        mk(10, 1'b1, 8'h5A, 16'h0043, 8'h00, 8, 0, 8, 0, 0, 0));

    // Reserved command: no busy and no strobe activity.
    @(posedge clk); #1;
    req = 1'b1; cmd = 2'b11; addr = 16'hBEEF;
    @(posedge clk); #1 req = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rsvd_busy", 32'(c_busy), 32'd0);
    check("rsvd_strobes", 32'(c_iorq + c_mreq + c_rd + c_wr + c_m1 + c_doe), 32'd0);

    // Reset during TW of a write: abandoned with no done.
    @(posedge clk); #1;
    req = 1'b1; cmd = 2'b00; addr = 16'h0080; wdata = 8'h5A;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 wait_n = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_in_cycle", 32'({iorq_n, wr_n, d_oe}), 32'b001);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_strobes", 32'({mreq_n, iorq_n, rd_n, wr_n, m1_n}), 32'h1f);
    check("mid_rst_ctl", 32'({d_oe, busy, done, err}), 32'h0);
    wait_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run("io_write_after_rst", 2'b00, 16'h0040, 8'h3C, 8'h00, 0, 0,
        mk(5, 1'b0, 8'h00, 16'h0040, 8'h3C, 3, 0, 0, 3, 0, 5));
    check("ctrl_out_after_rst", 32'(ctrl_reg), 32'h3C);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
